// File: rtl/batchnorm_pkg.sv
// Shared types and width helpers for the batch-normalisation block family.
// Accumulator widths are chosen so a full channel of extreme values cannot overflow.
package batchnorm_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        OUT   = 2'd2
    } bn_state_t;

    function automatic int sum_bits(input int width, input int log2n);
        return width + log2n + 1;
    endfunction

    function automatic int sumsq_bits(input int width, input int log2n);
        return 2 * width + log2n;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ch_bits(input int ch);
        return $clog2(ch) + 1;
    endfunction

endpackage

// File: rtl/fxp_round_shift.sv
// Signed right shift with round-half-away-from-zero; purely combinational.
// Works on the magnitude one bit wider than the input so the most negative value survives.
module fxp_round_shift #(
    parameter int IN_W_BITS  = 32,
    parameter int OUT_W_BITS = 16,
    parameter int SHIFT      = 1
) (
    input  logic signed [IN_W_BITS-1:0]  x,
    output logic signed [OUT_W_BITS-1:0] y
);

    generate
        if (SHIFT == 0) begin : g_pass
            assign y = OUT_W_BITS'(x);
        end else begin : g_round
            localparam int EW = IN_W_BITS + 1;
            localparam logic [EW-1:0] HALF = EW'(1) << (SHIFT - 1);

            logic                 neg;
            logic signed [EW-1:0] xe;
            logic        [EW-1:0] mag;
            logic        [EW-1:0] biased;
            logic        [EW-1:0] shifted;
            logic signed [EW-1:0] res;

            assign neg     = x[IN_W_BITS-1];
            assign xe      = EW'(x);
            assign mag     = neg ? -xe : xe;
            assign biased  = mag + HALF;
            assign shifted = biased >> SHIFT;
            assign res     = neg ? -$signed(shifted) : $signed(shifted);
            assign y       = OUT_W_BITS'(res);
        end
    endgenerate

endmodule

// File: rtl/batchnorm_stats.sv
// Per-channel mean and population variance over IN_H*IN_W elements; result valid two cycles
// after the last element of a channel. Input is stalled from the last element until the result is taken.
module batchnorm_stats
    import batchnorm_pkg::*;
#(
    parameter int CH    = 1,
    parameter int IN_H  = 1,
    parameter int IN_W  = 1,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  out_mean,
    output logic signed [WIDTH-1:0]  out_var,
    output logic [$clog2(CH):0]      out_ch,
    output logic                     out_last
);

    localparam int N     = IN_H * IN_W;
    localparam int LOG2N = $clog2(N);
    localparam int SW    = sum_bits(WIDTH, LOG2N);
    localparam int QW    = sumsq_bits(WIDTH, LOG2N);
    localparam int CW    = cnt_bits(N);
    localparam int CHW   = ch_bits(CH);
    localparam int PW    = 2 * WIDTH;
    localparam int VW    = PW + 1;

    localparam logic signed [VW-1:0]    VAR_LIMIT = {{(VW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] VAR_MAX   = {1'b0, {(WIDTH - 1){1'b1}}};

    bn_state_t state;
    bn_state_t state_nxt;

    logic signed [SW-1:0]    sum;
    logic signed [QW-1:0]    sumsq;
    logic        [CW-1:0]    cnt;
    logic        [CHW-1:0]   ch;

    logic                    in_fire;
    logic                    out_fire;
    logic                    last_elem;
    logic                    last_ch;

    logic signed [PW-1:0]    sq;
    logic signed [WIDTH-1:0] mean_r;
    logic signed [PW-1:0]    mean_sq;
    logic signed [PW-1:0]    ex2;
    logic signed [PW-1:0]    m2;
    logic signed [VW-1:0]    var_full;
    logic signed [WIDTH-1:0] var_sat;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_elem = (cnt == CW'(N - 1));
    assign last_ch   = (ch == CHW'(CH - 1));
    assign out_ch    = ch;
    assign out_last  = out_valid & last_ch;

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (in_fire && last_elem) state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     if (out_fire) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    assign sq = PW'(in_data) * PW'(in_data);

    fxp_round_shift #(
        .IN_W_BITS  (SW),
        .OUT_W_BITS (WIDTH),
        .SHIFT      (LOG2N)
    ) u_mean (
        .x (sum),
        .y (mean_r)
    );

    fxp_round_shift #(
        .IN_W_BITS  (QW),
        .OUT_W_BITS (PW),
        .SHIFT      (LOG2N + FRAC)
    ) u_ex2 (
        .x (sumsq),
        .y (ex2)
    );

    assign mean_sq = PW'(mean_r) * PW'(mean_r);

    fxp_round_shift #(
        .IN_W_BITS  (PW),
        .OUT_W_BITS (PW),
        .SHIFT      (FRAC)
    ) u_m2 (
        .x (mean_sq),
        .y (m2)
    );

    // Rounding of E[x^2] and mean^2 separately can push a near-zero variance slightly negative.
    always_comb begin
        var_full = VW'(ex2) - VW'(m2);
        var_sat  = var_full[WIDTH-1:0];
        if (var_full < 0) begin
            var_sat = '0;
        end else if (var_full > VAR_LIMIT) begin
            var_sat = VAR_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            sum      <= '0;
            sumsq    <= '0;
            cnt      <= '0;
            ch       <= '0;
            out_mean <= '0;
            out_var  <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                sum   <= sum + SW'(in_data);
                sumsq <= sumsq + QW'(sq);
                cnt   <= last_elem ? '0 : cnt + CW'(1);
            end
            if (state == CALC) begin
                out_mean <= mean_r;
                out_var  <= var_sat;
            end
            if (out_fire) begin
                sum   <= '0;
                sumsq <= '0;
                ch    <= last_ch ? '0 : ch + CHW'(1);
            end
        end
    end

endmodule

// File: tb/tb_batchnorm_stats.sv
// Directed and randomised-gap bench for batchnorm_stats with 2 channels of 2x2 elements.
module tb_batchnorm_stats;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_mean;
    logic signed [15:0] out_var;
    logic [1:0]         out_ch;
    logic               out_last;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] cur [4];
    logic [15:0]        em;
    logic [15:0]        ev;
    logic [1:0]         exp_ch;

    always #5 clk = ~clk;

    batchnorm_stats #(
        .CH    (2),
        .IN_H  (2),
        .IN_W  (2),
        .WIDTH (16),
        .FRAC  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mean  (out_mean),
        .out_var   (out_var),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $error("FAIL send_timeout: in_ready observed 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", out_valid, 1);
    endtask

    task automatic get_result(input int delay, input logic [15:0] m, input logic [15:0] v,
                              input logic [1:0] c, input logic l, input string tag);
        out_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < delay; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            @(negedge clk);
            check({tag, "_stall_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        check({tag, "_mean"}, out_mean, m);
        check({tag, "_var"},  out_var,  v);
        check({tag, "_ch"},   out_ch,   c);
        check({tag, "_last"}, out_last, l);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_ready"}, in_ready, 1);
    endtask

    function automatic longint rnd(input longint x, input int s);
        longint m;
        m = (x < 0) ? -x : x;
        m = (m + (longint'(1) << (s - 1))) / (longint'(1) << s);
        return (x < 0) ? -m : m;
    endfunction

    function automatic void model(output logic [15:0] m, output logic [15:0] v);
        longint s, q, mn, ex2, m2, vv;
        s = 0;
        q = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'(cur[i]);
            q += longint'(cur[i]) * longint'(cur[i]);
        end
        mn  = rnd(s, 2);
        ex2 = rnd(q, 10);
        m2  = rnd(mn * mn, 8);
        vv  = ex2 - m2;
        if (vv < 0) vv = 0;
        if (vv > 32767) vv = 32767;
        m = mn[15:0];
        v = vv[15:0];
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_mean", out_mean, 16'h0000);
        check("rst_var", out_var, 16'h0000);
        check("rst_ch", out_ch, 0);
        check("rst_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_in_ready", in_ready, 1);

        // Frame 1, channel 0: latency and a five-cycle consumer stall with junk input.
        repeat (4) send(16'h0100, 0);
        check("calc_out_valid", out_valid, 0);
        check("calc_in_ready", in_ready, 0);
        @(negedge clk);
        check("t2_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~i[0];
            in_data  = 16'h7777;
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_ready", in_ready, 0);
            check("stall_mean", out_mean, 16'h0100);
            check("stall_var", out_var, 16'h0000);
            check("stall_ch", out_ch, 0);
        end
        in_valid = 1'b0;
        get_result(0, 16'h0100, 16'h0000, 2'd0, 1'b0, "f1c0");
        send(16'h0100, 0); send(16'h0300, 0); send(16'h0100, 0); send(16'h0300, 0);
        get_result(0, 16'h0200, 16'h0100, 2'd1, 1'b1, "f1c1");

        // Frame 2: half-away rounding of a negative sum, then variance saturation.
        send(16'hFFFF, 0); send(16'hFFFF, 1); send(16'hFFFF, 0); send(16'hFFFE, 2);
        get_result(2, 16'hFFFF, 16'h0000, 2'd0, 1'b0, "round");
        send(16'h7FFF, 0); send(16'h8000, 0); send(16'h7FFF, 0); send(16'h8000, 0);
        get_result(1, 16'hFFFF, 16'h7FFF, 2'd1, 1'b1, "sat");

        // Reset while a result is presented.
        repeat (4) send(16'h0100, 0);
        wait_valid();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid_mid", out_valid, 0);
        check("rst_mean_mid", out_mean, 16'h0000);
        check("rst_var_mid", out_var, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) send(16'h0100, 0);
        get_result(0, 16'h0100, 16'h0000, 2'd0, 1'b0, "rst_c0");

        // Reset after two elements of channel 1.
        send(16'h0500, 0); send(16'h0700, 0);
        rst_n = 1'b0;
        #1;
        check("rst_ch_mid", out_ch, 0);
        check("rst_valid_mid2", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0100, 0); send(16'h0300, 0); send(16'h0100, 0); send(16'h0300, 0);
        get_result(1, 16'h0200, 16'h0100, 2'd0, 1'b0, "after_rst");

        // Three frames with random gaps against the reference model.
        exp_ch = 2'd1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (k == 5) cur[i] = 16'($urandom);
                else        cur[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
            end
            for (int i = 0; i < 4; i++) send(cur[i], int'($urandom_range(0, 3)));
            model(em, ev);
            get_result(int'($urandom_range(0, 4)), em, ev, exp_ch, exp_ch == 2'd1, "rand");
            exp_ch = (exp_ch == 2'd1) ? 2'd0 : 2'd1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
